// File: rtl/pipe_normalizer.sv
// Two-stage floating-point post-add normaliser: leading-one detect, then
// shift, round (truncate or RNE), exponent adjust and status flags.
module pipe_normalizer #(
    parameter int MANTISSA_N = 25,
    parameter int EXP_N      = 8,
    parameter int EXT_N      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_srst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [MANTISSA_N-1:0] i_mantissa,
    input  logic [EXT_N-1:0]      i_ext,
    input  logic [EXP_N-1:0]      i_exp,
    input  logic                  i_round_mode,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [MANTISSA_N-1:0] o_normed_mantissa,
    output logic [EXP_N-1:0]      o_normed_exp,
    output logic                  o_zero,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int W_N   = MANTISSA_N + EXT_N;
    localparam int IDX_N = $clog2(W_N);
    localparam int SE_N  = EXP_N + 2;

    localparam logic [SE_N-1:0]       EXP_MAX    = SE_N'((2 ** EXP_N) - 1);
    localparam logic [SE_N-1:0]       EXP_ONE    = SE_N'(1);
    localparam logic [MANTISSA_N-1:0] HIDDEN_ONE = MANTISSA_N'(1) << (MANTISSA_N - 2);
    localparam logic [IDX_N-1:0]      HIDDEN_POS = IDX_N'(W_N - 2);

    // Handshake
    logic w_load1;
    logic w_load2;
    logic w_accept;
    logic r1_valid;
    logic r2_valid;

    assign w_load2    = ~r2_valid | i_out_ready;
    assign w_load1    = ~r1_valid | w_load2;
    assign w_accept   = i_in_valid & w_load1;
    assign o_in_ready = w_load1;
    assign o_out_valid = r2_valid;

    // Stage 1: leading-one detection on the extended word
    logic [W_N-1:0]   w_word;
    logic [IDX_N-1:0] w_lead_idx;
    logic             w_word_zero;

    assign w_word      = {i_mantissa, i_ext};
    assign w_word_zero = ~|w_word;

    always_comb begin
        w_lead_idx = '0;
        for (int i = 0; i < W_N; i++) begin
            if (w_word[i]) begin
                w_lead_idx = IDX_N'(i);
            end
        end
    end

    logic [W_N-1:0]   r1_word;
    logic [EXP_N-1:0] r1_exp;
    logic             r1_round_mode;
    logic [IDX_N-1:0] r1_lead_idx;
    logic             r1_zero;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r1_valid <= 1'b0;
        end else if (w_load1) begin
            r1_valid <= i_in_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r1_word       <= w_word;
            r1_exp        <= i_exp;
            r1_round_mode <= i_round_mode;
            r1_lead_idx   <= w_lead_idx;
            r1_zero       <= w_word_zero;
        end
    end

    // Stage 2: alignment of the hidden bit to MANTISSA_N-2 of the mantissa field
    logic [IDX_N-1:0]      w_lshift;
    logic [W_N-1:0]        w_shifted;
    logic [SE_N-1:0]       w_exp_base;
    logic [SE_N-1:0]       w_exp_shift;

    assign w_lshift   = HIDDEN_POS - r1_lead_idx;
    assign w_exp_base = {2'b00, r1_exp};

    always_comb begin
        if (r1_word[W_N-1]) begin
            // Carry-out: drop one bit but keep it visible as sticky
            w_shifted   = {1'b0, r1_word[W_N-1:2], r1_word[1] | r1_word[0]};
            w_exp_shift = w_exp_base + EXP_ONE;
        end else begin
            w_shifted   = r1_word << w_lshift;
            w_exp_shift = w_exp_base - SE_N'(w_lshift);
        end
    end

    logic [MANTISSA_N-1:0] w_mant;
    logic                  w_guard;
    logic                  w_rs;
    logic                  w_inc;
    logic [MANTISSA_N-1:0] w_mant_rnd;
    logic [MANTISSA_N-1:0] w_mant_fin;
    logic [SE_N-1:0]       w_exp_fin;

    assign w_mant     = w_shifted[W_N-1:EXT_N];
    assign w_guard    = w_shifted[EXT_N-1];
    assign w_rs       = |w_shifted[EXT_N-2:0];
    assign w_inc      = r1_round_mode & w_guard & (w_rs | w_mant[0]);
    assign w_mant_rnd = w_mant + MANTISSA_N'(w_inc);

    // A rounding carry leaves only the MSB set, so the renormalising shift loses nothing
    always_comb begin
        if (w_mant_rnd[MANTISSA_N-1]) begin
            w_mant_fin = w_mant_rnd >> 1;
            w_exp_fin  = w_exp_shift + EXP_ONE;
        end else begin
            w_mant_fin = w_mant_rnd;
            w_exp_fin  = w_exp_shift;
        end
    end

    logic w_overflow;
    logic w_underflow;

    assign w_overflow  = ~r1_zero & ($signed(w_exp_fin) >= $signed(EXP_MAX));
    assign w_underflow = ~r1_zero & ($signed(w_exp_fin) <  $signed(EXP_ONE));

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r2_valid          <= 1'b0;
            o_normed_mantissa <= '0;
            o_normed_exp      <= '0;
            o_zero            <= 1'b0;
            o_overflow        <= 1'b0;
            o_underflow       <= 1'b0;
        end else if (w_load2) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                o_zero      <= r1_zero;
                o_overflow  <= w_overflow;
                o_underflow <= w_underflow;
                if (r1_zero || w_underflow) begin
                    o_normed_mantissa <= '0;
                    o_normed_exp      <= '0;
                end else if (w_overflow) begin
                    o_normed_mantissa <= HIDDEN_ONE;
                    o_normed_exp      <= '1;
                end else begin
                    o_normed_mantissa <= w_mant_fin;
                    o_normed_exp      <= w_exp_fin[EXP_N-1:0];
                end
            end
        end
    end

endmodule
